// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive FSM states, frame-shape defaults and the
// processor-side register map.
package spart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic [1:0] ADDR_DATA    = 2'b00;
    localparam logic [1:0] ADDR_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO  = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 so an idle
// serial line does not look like a start bit coming out of reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Double-register the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: recovers 8N1 frames from rxd using the 16x oversample
// enable and holds each byte with ready/error flags for the processor.
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_r_enable,
    input  logic                 rxd,
    input  logic                 rec_enable,
    output logic [DATA_BITS-1:0] data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE) + 1;
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [TW-1:0] HALF_TICKS  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] FULL_TICKS  = TW'(OVERSAMPLE);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    logic                 rxs_s;
    rx_state_t            state_r;
    logic [TW-1:0]        tick_cnt_r;
    logic [TW-1:0]        tick_nxt_s;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 stop_bit_r;
    logic                 commit_r;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs_s)
    );

    assign tick_nxt_s = tick_cnt_r + TW'(1);

    // Frame FSM plus the processor-visible byte/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            tick_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            stop_bit_r  <= 1'b1;
            commit_r    <= 1'b0;
            data        <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            commit_r <= 1'b0;
            if (baud_r_enable) begin
                case (state_r)
                    IDLE: begin
                        if (!rxs_s) begin
                            state_r    <= START;
                            tick_cnt_r <= TW'(1);
                        end else begin
                            tick_cnt_r <= '0;
                        end
                    end
                    START: begin
                        // The tick that saw the falling edge counts as 1.
                        if (tick_nxt_s == HALF_TICKS) begin
                            tick_cnt_r <= '0;
                            bit_cnt_r  <= '0;
                            state_r    <= rxs_s ? IDLE : DATA;
                        end else begin
                            tick_cnt_r <= tick_nxt_s;
                        end
                    end
                    DATA: begin
                        if (tick_nxt_s == FULL_TICKS) begin
                            tick_cnt_r <= '0;
                            shift_r    <= {rxs_s, shift_r[DATA_BITS-1:1]};
                            if (bit_cnt_r == LAST_BIT) begin
                                bit_cnt_r <= '0;
                                state_r   <= STOP;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BW'(1);
                            end
                        end else begin
                            tick_cnt_r <= tick_nxt_s;
                        end
                    end
                    STOP: begin
                        if (tick_nxt_s == FULL_TICKS) begin
                            tick_cnt_r <= '0;
                            stop_bit_r <= rxs_s;
                            commit_r   <= 1'b1;
                            state_r    <= IDLE;
                        end else begin
                            tick_cnt_r <= tick_nxt_s;
                        end
                    end
                    default: begin
                        state_r    <= IDLE;
                        tick_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                    end
                endcase
            end

            // A commit on the same cycle as a read replaces the consumed byte.
            if (commit_r) begin
                data        <= shift_r;
                rda         <= 1'b1;
                framing_err <= ~stop_bit_r;
                overrun     <= rda & ~rec_enable;
            end else if (rec_enable) begin
                rda         <= 1'b0;
                framing_err <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: frames are driven bit by bit, expected bytes
// and flags are queued at send time and compared after each stop bit.
module tb_spart_rx;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_r_enable;
    logic       rxd;
    logic       rec_enable;
    logic [7:0] data;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       ovr;
    } exp_t;

    exp_t sb_q[$];

    spart_rx dut (
        .clk           (clk),
        .rst           (rst),
        .baud_r_enable (baud_r_enable),
        .rxd           (rxd),
        .rec_enable    (rec_enable),
        .data          (data),
        .rda           (rda),
        .framing_err   (framing_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // One baud tick every 4 clocks: a bit period is 64 clocks.
    initial begin
        baud_r_enable = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 baud_r_enable = 1'b1;
            @(posedge clk);
            #1 baud_r_enable = 1'b0;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] b, input logic fe, input logic ovr);
        exp_t e;
        e.data = b;
        e.fe   = fe;
        e.ovr  = ovr;
        sb_q.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_rda"},  {7'd0, rda},         8'd1);
            check({tag, "_data"}, data,                e.data);
            check({tag, "_fe"},   {7'd0, framing_err}, {7'd0, e.fe});
            check({tag, "_ovr"},  {7'd0, overrun},     {7'd0, e.ovr});
        end
    endtask

    task automatic read_pulse();
        rec_enable = 1'b1;
        clks(1);
        rec_enable = 1'b0;
    endtask

    // Full 10-bit frame; optionally strobes rec_enable on the commit cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rd_at_commit);
        rxd = 1'b0;
        clks(64);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            clks(64);
        end
        rxd = stop_bit;
        for (int i = 0; i < 64; i++) begin
            clks(1);
            if (rd_at_commit && dut.commit_r) begin
                rec_enable = 1'b1;
                clks(1);
                rec_enable = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        rxd        = 1'b1;
        rec_enable = 1'b0;
        clks(3);
        check("rst_data", data, 8'h00);
        check("rst_rda",  {7'd0, rda}, 8'd0);
        check("rst_fe",   {7'd0, framing_err}, 8'd0);
        check("rst_ovr",  {7'd0, overrun}, 8'd0);
        rst = 1'b0;
        clks(20);

        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        check_sb("a5");
        read_pulse();
        check("a5_read_rda",  {7'd0, rda}, 8'd0);
        check("a5_read_data", data, 8'hA5);

        rxd = 1'b0;
        clks(20);
        rxd = 1'b1;
        clks(128);
        check("glitch_rda", {7'd0, rda}, 8'd0);
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check_sb("3c");
        read_pulse();

        push_exp(8'h00, 1'b1, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0);
        check_sb("ferr");
        read_pulse();
        check("ferr_read_rda", {7'd0, rda}, 8'd0);
        check("ferr_read_fe",  {7'd0, framing_err}, 8'd0);
        // Line stays low: a second all-zero frame must be picked up.
        clks(589);
        rxd = 1'b1;
        clks(40);
        check("relow_rda",  {7'd0, rda}, 8'd1);
        check("relow_data", data, 8'h00);
        check("relow_fe",   {7'd0, framing_err}, 8'd1);
        check("relow_ovr",  {7'd0, overrun}, 8'd0);
        read_pulse();
        clks(200);

        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        check_sb("ovr_first");
        push_exp(8'h22, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        check_sb("ovr_second");
        read_pulse();
        check("ovr_read_rda",  {7'd0, rda}, 8'd0);
        check("ovr_read_fe",   {7'd0, framing_err}, 8'd0);
        check("ovr_read_ovr",  {7'd0, overrun}, 8'd0);
        check("ovr_read_data", data, 8'h22);

        push_exp(8'h33, 1'b0, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        check_sb("pre_same");
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1);
        check_sb("same_cycle");

        rxd = 1'b0;
        clks(64);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            clks(64);
        end
        clks(32);
        rst = 1'b1;
        #1;
        check("midrst_data",  data, 8'h00);
        check("midrst_rda",   {7'd0, rda}, 8'd0);
        check("midrst_fe",    {7'd0, framing_err}, 8'd0);
        check("midrst_ovr",   {7'd0, overrun}, 8'd0);
        check("midrst_state", 8'(dut.state_r), 8'(IDLE));
        clks(2);
        rst = 1'b0;
        clks(64 * 6);
        check("post_rst_rda", {7'd0, rda}, 8'd0);
        push_exp(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        check_sb("81");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Serial receive half of the SPART. Recovers 8N1 asynchronous frames from `rxd` and presents each byte to the processor-side bus with a ready flag.
- Timed by the 16x-oversample receive enable from the baud downcounter. Sits beside the transmitter inside the SPART top.
- The processor read strobe (iocs, ioaddr=00, iorw=1, decoded in the top) consumes the byte.

Parameters:
- OVERSAMPLE, 16, baud enable ticks per bit period (power of two, >=8).
- DATA_BITS, 8, payload bits per frame, sent LSB first.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- baud_r_enable  in  1  one-clk pulse at OVERSAMPLE x baud rate.
- rxd  in  1  asynchronous serial input; idle level is 1.
- rec_enable  in  1  one-clk read strobe; consumes the held byte.
- data  out  DATA_BITS  last received byte; holds until the next byte completes.
- rda  out  1  receive data available.
- framing_err  out  1  stop bit of the held byte sampled as 0.
- overrun  out  1  a byte completed while rda was still 1.

Behaviour:
- Reset (async, rst=1) values:
  - data=0, rda=0, framing_err=0, overrun=0.
  - FSM=IDLE, tick counter=0, bit counter=0.
  - Synchronizer flops=1.
- Input path:
  - rxd passes through a 2-flop synchronizer; all logic below uses the synchronized value `rxs`.
  - Counters and sampling advance only on cycles where baud_r_enable=1.
- FSM:
  - IDLE: tick counter held at 0. On a tick with rxs=0, go to START with counter=1.
  - START: count ticks. At count OVERSAMPLE/2 (mid start bit), sample rxs:
    - rxs=1: glitch; return to IDLE.
    - rxs=0: go to DATA, counter=0, bit counter=0.
  - DATA: count ticks. Every OVERSAMPLE ticks (bit midpoint), shift rxs into the MSB of the shift register (right shift, so LSB-first arrival ends LSB-aligned) and increment the bit counter. After DATA_BITS samples, go to STOP with counter=0.
  - STOP: at OVERSAMPLE ticks, sample rxs and commit (below), then go to IDLE. Do not wait for the line to return high; a 0 stop bit with the line still low restarts START detection on the next tick.
- Commit, registered in the clk cycle after the stop-sample tick:
  - data <= shift register.
  - rda <= 1.
  - framing_err <= ~stop_sample.
  - overrun <= rda_prev & ~rec_enable.
- Read:
  - rec_enable=1 with no commit that cycle: next cycle rda=0, framing_err=0, overrun=0. data is unchanged.
  - rec_enable=1 with rda=0 has no effect.
- Simultaneous commit and rec_enable: the commit wins.
  - rda stays 1; data and framing_err take the new values.
  - overrun=0, because the old byte was consumed.
- Overrun: the new byte overwrites data; overrun stays 1 until the next read.
- Reset mid-frame: abort immediately to the reset state. The partial byte is discarded and no commit occurs.
- No ticks (baud_r_enable stuck 0): the FSM freezes. Outputs still respond to rec_enable.
- Width rules:
  - Tick counter is log2(OVERSAMPLE)+1 bits; bit counter is log2(DATA_BITS)+1 bits.
  - Neither counter wraps inside a state; each resets on every state transition.

Decomposition:
- Shared package `spart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - OVERSAMPLE and DATA_BITS defaults.
  - SPART register address constants (00 data, 01 status, 10/11 divisor).
- One natural sub-module, `sync2`: the 2-flop synchronizer with reset value 1, also reusable for the transmitter's handshake inputs.
- Everything else stays in spart_rx.

Test Plan:
- Frame 0xA5, good stop bit; tick every 4 clks (one bit = 64 clks) -> rda=1 about 8 clks after the stop midpoint, data=8'hA5, framing_err=0, overrun=0. rec_enable pulse -> rda=0 next cycle, data still 8'hA5.
- Start glitch: rxd low for 5 ticks (< OVERSAMPLE/2), then high -> FSM back to IDLE, rda stays 0. A following valid frame 0x3C is received correctly.
- Frame 0x00 with stop bit=0 -> rda=1, data=8'h00, framing_err=1. Line held low afterwards -> new START detected, no hang.
- Two frames 0x11 then 0x22 with no read -> after the second, data=8'h22, rda=1, overrun=1. rec_enable -> all three flags clear.
- rec_enable asserted on the same clk as the commit of 0x5A (previous byte unread) -> rda=1, data=8'h5A, overrun=0.
- rst pulsed mid data bit 4 of frame 0xFF -> all outputs 0 and FSM IDLE immediately. The next frame 0x81 is received as 8'h81.
